bsg_chip_link_bringup_ctrl: RTL and testbench
=============================================

BSG_CHIP_LINK_BRINGUP_CTRL -- requirements
Module: bsg_chip_link_bringup_ctrl

Interface
REQ-001 SHALL have parameter num_links_p, default 2: number of physical links sequenced.
REQ-002 SHALL have parameter reset_cycles_p, default 16: length of the all-reset phase, in cycles (>=1).
REQ-003 SHALL have parameter settle_cycles_p, default 64: length of each release/settle phase, in cycles (>=1).
REQ-004 SHALL have parameter timeout_cycles_p, default 1024: maximum length of the ready-wait phase, in cycles (>=1).
REQ-005 SHALL use one clock and an asynchronous, active-low reset, with ports clk_i and reset_n_i.
REQ-006 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-007 reset_n_i  in  1  asynchronous active-low reset.
REQ-008 start_i  in  1  request a bring-up; sampled only in IDLE, DONE or FAIL.
REQ-009 link_mask_i  in  num_links_p  links to bring up; latched on an accepted start.
REQ-010 link_ready_i  in  num_links_p  per-link ready (token/credit seen), synchronous to clk_i.
REQ-011 up_reset_o  out  num_links_p  per-link upstream (transmit side) reset, active-high.
REQ-012 down_reset_o  out  num_links_p  per-link downstream (receive side) reset, active-high.
REQ-013 busy_o  out  1  high in ASSERT, REL_UP, REL_DOWN and WAIT_READY.
REQ-014 done_o  out  1  level output, high in the DONE state.
REQ-015 fail_o  out  1  level output, high in the FAIL state.
REQ-016 fail_mask_o  out  num_links_p  masked links not ready at timeout; valid while fail_o is high, else 0.

Function
REQ-017 SHALL implement the states IDLE, ASSERT, REL_UP, REL_DOWN, WAIT_READY, DONE and FAIL.
REQ-018 An accepted start_i at edge t SHALL latch link_mask_i into mask_r and enter ASSERT at t+1.
REQ-019 Start with link_mask_i==0 SHALL go directly to DONE; resets unchanged; no other phase entered.
REQ-020 start_i during busy_o SHALL be ignored; mask_r unchanged.
REQ-021 ASSERT SHALL hold up_reset_o and down_reset_o at all-ones for exactly reset_cycles_p cycles, then enter REL_UP.
REQ-022 REL_UP SHALL drive up_reset_o = ~mask_r with down_reset_o all-ones, for exactly settle_cycles_p cycles, then enter REL_DOWN.
REQ-023 REL_DOWN SHALL drive down_reset_o = ~mask_r, for exactly settle_cycles_p cycles, then enter WAIT_READY.
REQ-024 From REL_DOWN onward up_reset_o and down_reset_o SHALL remain at ~mask_r through WAIT_READY, DONE and FAIL.
REQ-025 Unmasked links SHALL keep both resets asserted in every state.
REQ-026 In WAIT_READY, in the first cycle with (link_ready_i & mask_r)==mask_r, the block SHALL enter DONE on the next edge.
REQ-027 WAIT_READY SHALL enter FAIL after exactly timeout_cycles_p cycles without meeting REQ-026, and SHALL capture fail_mask_o = mask_r & ~link_ready_i from the final cycle.
REQ-028 If ready is met in the final timeout cycle, DONE SHALL win.
REQ-029 link_ready_i SHALL be ignored outside WAIT_READY.
REQ-030 Phase counter width SHALL be clog2(max(reset_cycles_p, settle_cycles_p, timeout_cycles_p)+1); it SHALL clear on every state change and SHALL never wrap.
REQ-031 An accepted start in DONE or FAIL SHALL restart the sequence at ASSERT, reasserting all resets; done_o, fail_o and fail_mask_o SHALL clear at the same edge.

Reset
REQ-032 While reset_n_i is low, the block SHALL force state IDLE, counter 0, mask_r 0, up_reset_o and down_reset_o all-ones, and busy_o, done_o, fail_o and fail_mask_o 0, asynchronously.
REQ-033 Deassertion of reset_n_i SHALL take effect at the first clk_i edge; reset mid-sequence SHALL abort to IDLE with all link resets asserted.

Verification
REQ-034 Nominal (defaults), mask=2'b11, ready=2'b11 from start -> ASSERT 16 cycles, REL_UP 64 cycles, REL_DOWN 64 cycles; done_o high 1 cycle after entering WAIT_READY; resets=2'b00.
REQ-035 Timeout, mask=2'b11, ready=2'b01 held -> fail_o after 1024 WAIT_READY cycles; fail_mask_o=2'b10; resets stay 2'b00.
REQ-036 Partial mask, mask=2'b10 -> up_reset_o/down_reset_o bit 0 stay 1 throughout; bit 1 releases per REQ-022/023.
REQ-037 Edge cases: mask=0 -> done_o at t+1, busy_o never high; start pulses during busy ignored; ready arriving in cycle 1024 -> DONE, not FAIL.
REQ-038 reset_n_i low mid-REL_DOWN -> outputs immediately all resets 1 and busy_o 0; a fresh start then runs the full sequence.

Source files
------------

// File: rtl/bsg_chip_link_bringup_ctrl.sv
// Sequences per-link upstream/downstream reset release, then waits for link ready or times out.
// Latency: start accepted at edge t enters ASSERT at t+1; no backpressure, start ignored while busy.
module bsg_chip_link_bringup_ctrl #(
    parameter int num_links_p      = 2,
    parameter int reset_cycles_p   = 16,
    parameter int settle_cycles_p  = 64,
    parameter int timeout_cycles_p = 1024
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   start_i,
    input  logic [num_links_p-1:0] link_mask_i,
    input  logic [num_links_p-1:0] link_ready_i,
    output logic [num_links_p-1:0] up_reset_o,
    output logic [num_links_p-1:0] down_reset_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   fail_o,
    output logic [num_links_p-1:0] fail_mask_o
);

    localparam int max_ab_lp = (reset_cycles_p > settle_cycles_p) ? reset_cycles_p : settle_cycles_p;
    localparam int max_lp    = (max_ab_lp > timeout_cycles_p) ? max_ab_lp : timeout_cycles_p;
    localparam int cnt_w_lp  = $clog2(max_lp + 1);

    localparam logic [cnt_w_lp-1:0] reset_last_lp   = cnt_w_lp'(reset_cycles_p - 1);
    localparam logic [cnt_w_lp-1:0] settle_last_lp  = cnt_w_lp'(settle_cycles_p - 1);
    localparam logic [cnt_w_lp-1:0] timeout_last_lp = cnt_w_lp'(timeout_cycles_p - 1);
    localparam logic [cnt_w_lp-1:0] cnt_max_lp      = cnt_w_lp'(max_lp);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ASSERT,
        S_REL_UP,
        S_REL_DOWN,
        S_WAIT_READY,
        S_DONE,
        S_FAIL
    } state_e;

    state_e                  state_r, state_n;
    logic [cnt_w_lp-1:0]     cnt_r;
    logic [num_links_p-1:0]  mask_r;
    logic [num_links_p-1:0]  fail_mask_r;
    logic                    load_mask;
    logic                    capture_fail;
    logic                    timed;
    logic                    all_ready;

    assign all_ready = ((link_ready_i & mask_r) == mask_r);

    always_comb begin
        state_n      = state_r;
        load_mask    = 1'b0;
        capture_fail = 1'b0;
        timed        = 1'b0;
        case (state_r)
            S_IDLE, S_DONE, S_FAIL: begin
                if (start_i) begin
                    load_mask = 1'b1;
                    // An empty mask has nothing to sequence, so it completes immediately.
                    state_n   = (link_mask_i == '0) ? S_DONE : S_ASSERT;
                end
            end
            S_ASSERT: begin
                timed = 1'b1;
                if (cnt_r == reset_last_lp) state_n = S_REL_UP;
            end
            S_REL_UP: begin
                timed = 1'b1;
                if (cnt_r == settle_last_lp) state_n = S_REL_DOWN;
            end
            S_REL_DOWN: begin
                timed = 1'b1;
                if (cnt_r == settle_last_lp) state_n = S_WAIT_READY;
            end
            S_WAIT_READY: begin
                timed = 1'b1;
                // Ready takes priority over timeout in the last cycle.
                if (all_ready) begin
                    state_n = S_DONE;
                end else if (cnt_r == timeout_last_lp) begin
                    state_n      = S_FAIL;
                    capture_fail = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r     <= S_IDLE;
            cnt_r       <= '0;
            mask_r      <= '0;
            fail_mask_r <= '0;
        end else begin
            state_r <= state_n;
            if (state_n != state_r) begin
                cnt_r <= '0;
            end else if (timed && (cnt_r != cnt_max_lp)) begin
                cnt_r <= cnt_r + 1'b1;
            end
            if (load_mask) begin
                mask_r      <= link_mask_i;
                fail_mask_r <= '0;
            end else if (capture_fail) begin
                fail_mask_r <= mask_r & ~link_ready_i;
            end
        end
    end

    // Unmasked links see ~mask_r == 1, so they stay in reset in every state.
    always_comb begin
        up_reset_o   = '1;
        down_reset_o = '1;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        fail_o       = 1'b0;
        fail_mask_o  = '0;
        case (state_r)
            S_ASSERT: begin
                busy_o = 1'b1;
            end
            S_REL_UP: begin
                busy_o     = 1'b1;
                up_reset_o = ~mask_r;
            end
            S_REL_DOWN, S_WAIT_READY: begin
                busy_o       = 1'b1;
                up_reset_o   = ~mask_r;
                down_reset_o = ~mask_r;
            end
            S_DONE: begin
                done_o       = 1'b1;
                up_reset_o   = ~mask_r;
                down_reset_o = ~mask_r;
            end
            S_FAIL: begin
                fail_o       = 1'b1;
                fail_mask_o  = fail_mask_r;
                up_reset_o   = ~mask_r;
                down_reset_o = ~mask_r;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bsg_chip_link_bringup_ctrl.sv
// Directed bench for bsg_chip_link_bringup_ctrl with default parameters; phase lengths are
// measured from the reset outputs and compared against a queue of expected sequence results.
module tb_bsg_chip_link_bringup_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [1:0] link_mask;
    logic [1:0] link_ready;
    logic [1:0] up_reset;
    logic [1:0] down_reset;
    logic       busy;
    logic       done;
    logic       fail;
    logic [1:0] fail_mask;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int         n_a;
        int         n_u;
        int         n_d;
        logic       done;
        logic       fail;
        logic [1:0] fmask;
        logic [1:0] rst;
    } exp_t;

    exp_t sb[$];

    bsg_chip_link_bringup_ctrl #(
        .num_links_p      (2),
        .reset_cycles_p   (16),
        .settle_cycles_p  (64),
        .timeout_cycles_p (1024)
    ) dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .start_i      (start),
        .link_mask_i  (link_mask),
        .link_ready_i (link_ready),
        .up_reset_o   (up_reset),
        .down_reset_o (down_reset),
        .busy_o       (busy),
        .done_o       (done),
        .fail_o       (fail),
        .fail_mask_o  (fail_mask)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [1:0] mask, input exp_t e);
        sb.push_back(e);
        link_mask = mask;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        link_mask = 2'($urandom);
    endtask

    // Walks one sequence cycle by cycle, classifying each busy cycle by its reset pattern.
    task automatic observe(input string tag, input logic [1:0] mask, input int late_at,
                           input logic [1:0] rdy_late, input int poke_at);
        int         c   = 1;
        int         n_a = 0;
        int         n_u = 0;
        int         n_d = 0;
        int         n_o = 0;
        logic [1:0] nm  = ~mask;
        exp_t       e;
        while (busy && c < 4000) begin
            if (done || fail || fail_mask != 2'b00) n_o++;
            else if (up_reset == 2'b11 && down_reset == 2'b11) n_a++;
            else if (up_reset == nm && down_reset == 2'b11) n_u++;
            else if (up_reset == nm && down_reset == nm) n_d++;
            else n_o++;
            if (c == late_at) link_ready = rdy_late;
            if (c == poke_at) begin
                start     = 1'b1;
                link_mask = ~mask;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        e = sb.pop_front();
        check({tag, ".assert_cycles"}, n_a, e.n_a);
        check({tag, ".relup_cycles"}, n_u, e.n_u);
        check({tag, ".down_cycles"}, n_d, e.n_d);
        check({tag, ".bad_cycles"}, n_o, 0);
        check({tag, ".ended"}, {31'b0, busy}, 0);
        check({tag, ".done"}, {31'b0, done}, {31'b0, e.done});
        check({tag, ".fail"}, {31'b0, fail}, {31'b0, e.fail});
        check({tag, ".fail_mask"}, {30'b0, fail_mask}, {30'b0, e.fmask});
        check({tag, ".up_reset"}, {30'b0, up_reset}, {30'b0, e.rst});
        check({tag, ".down_reset"}, {30'b0, down_reset}, {30'b0, e.rst});
    endtask

    initial begin
        reset_n    = 1'b0;
        start      = 1'b0;
        link_mask  = 2'b00;
        link_ready = 2'b00;
        #12;
        check("rst.up_reset", {30'b0, up_reset}, 3);
        check("rst.down_reset", {30'b0, down_reset}, 3);
        check("rst.busy", {31'b0, busy}, 0);
        check("rst.done", {31'b0, done}, 0);
        check("rst.fail", {31'b0, fail}, 0);
        check("rst.fail_mask", {30'b0, fail_mask}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Nominal, with a start poke during ASSERT/REL_UP that must be ignored.
        link_ready = 2'b11;
        launch(2'b11, '{16, 64, 65, 1'b1, 1'b0, 2'b00, 2'b00});
        observe("nominal", 2'b11, 0, 2'b00, 50);

        // Timeout with link 1 never ready; restart from DONE.
        link_ready = 2'b01;
        launch(2'b11, '{16, 64, 1088, 1'b0, 1'b1, 2'b10, 2'b00});
        observe("timeout", 2'b11, 0, 2'b00, 0);

        // Partial mask restarted from FAIL; link 0 stays in reset.
        link_ready = 2'b10;
        launch(2'b10, '{16, 64, 65, 1'b1, 1'b0, 2'b00, 2'b01});
        observe("partial", 2'b10, 0, 2'b00, 100);

        // Ready arrives in the final timeout cycle: DONE wins.
        link_ready = 2'b00;
        launch(2'b11, '{16, 64, 1088, 1'b1, 1'b0, 2'b00, 2'b00});
        observe("ready_last", 2'b11, 1168, 2'b11, 0);

        // Ready arrives one cycle too late: FAIL, both links flagged.
        link_ready = 2'b00;
        launch(2'b11, '{16, 64, 1088, 1'b0, 1'b1, 2'b11, 2'b00});
        observe("ready_late", 2'b11, 1169, 2'b11, 0);

        // Empty mask goes straight to DONE with every link held in reset.
        link_ready = 2'b11;
        launch(2'b00, '{0, 0, 0, 1'b1, 1'b0, 2'b00, 2'b11});
        observe("zero_mask", 2'b00, 0, 2'b00, 0);

        // Reset asserted in the middle of REL_DOWN.
        link_mask = 2'b11;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (99) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midrst.up_reset", {30'b0, up_reset}, 3);
        check("midrst.down_reset", {30'b0, down_reset}, 3);
        check("midrst.busy", {31'b0, busy}, 0);
        check("midrst.done", {31'b0, done}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        link_ready = 2'b11;
        launch(2'b11, '{16, 64, 65, 1'b1, 1'b0, 2'b00, 2'b00});
        observe("after_rst", 2'b11, 0, 2'b00, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
